// File: rtl/add_sub_shf_pipe.sv
// Pipelined bidirectional barrel shifter (left / logical right / arithmetic right) with a sticky
// output for mantissa alignment and an elastic valid/ready pipeline of PIPE_STAGES registers.
module add_sub_shf_pipe #(
   parameter int SIZE_DATA   = 32,
   parameter int SIZE_SHIFT  = 5,
   parameter int PIPE_STAGES = 2
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic                  i_flush,
   input  logic                  i_valid,
   output logic                  o_ready,
   input  logic                  i_dir,
   input  logic                  i_arith,
   input  logic [SIZE_SHIFT-1:0] i_shift_number,
   input  logic [SIZE_DATA-1:0]  i_data,
   output logic                  o_valid,
   input  logic                  i_ready,
   output logic [SIZE_DATA-1:0]  o_data,
   output logic                  o_sticky
);

   localparam int BPS  = (SIZE_SHIFT + PIPE_STAGES - 1) / PIPE_STAGES;
   localparam int LAST = PIPE_STAGES - 1;

   logic                  vld_p    [PIPE_STAGES];
   logic [SIZE_DATA-1:0]  data_p   [PIPE_STAGES];
   logic                  sticky_p [PIPE_STAGES];
   logic                  dir_p    [PIPE_STAGES];
   logic                  arith_p  [PIPE_STAGES];
   logic                  sign_p   [PIPE_STAGES];
   logic [SIZE_SHIFT-1:0] shift_p  [PIPE_STAGES];

   logic                  vin_n    [PIPE_STAGES];
   logic [SIZE_DATA-1:0]  data_n   [PIPE_STAGES];
   logic                  sticky_n [PIPE_STAGES];
   logic                  dir_n    [PIPE_STAGES];
   logic                  arith_n  [PIPE_STAGES];
   logic                  sign_n   [PIPE_STAGES];
   logic [SIZE_SHIFT-1:0] shift_n  [PIPE_STAGES];
   logic                  adv      [PIPE_STAGES];

   // One power-of-two step; returns {sticky, data}. Steps as wide as the word flush it to fill.
   function automatic logic [SIZE_DATA:0] shift_step(input logic [SIZE_DATA-1:0] d,
                                                     input logic st, input logic dir,
                                                     input logic fill, input int k);
      logic [SIZE_DATA-1:0] ones;
      logic [SIZE_DATA-1:0] fillv;
      logic [SIZE_DATA-1:0] r;
      logic                 s;
      int                   amt;
      ones  = '1;
      fillv = {SIZE_DATA{fill}};
      if (k >= 30 || (32'sd1 << k) >= SIZE_DATA) begin
         r = fillv;
         s = st | (dir & (|d));
      end else begin
         amt = 32'sd1 << k;
         if (dir) begin
            r = (d >> amt) | (fillv << (SIZE_DATA - amt));
            s = st | (|(d & ~(ones << amt)));
         end else begin
            r = d << amt;
            s = st;
         end
      end
      return {s, r};
   endfunction

   // A stage can take new contents when it, or any stage after it, is empty, or the sink is ready.
   always_comb begin
      logic chain;
      chain = i_ready;
      for (int s = LAST; s >= 0; s--) begin
         chain  = chain || !vld_p[s];
         adv[s] = chain;
      end
   end

   always_comb begin
      logic [SIZE_DATA-1:0]  cd;
      logic [SIZE_SHIFT-1:0] csh;
      logic [SIZE_DATA:0]    res;
      logic                  cs;
      logic                  cdir;
      logic                  car;
      logic                  csg;
      int                    p;
      cd  = '0;
      csh = '0;
      res = '0;
      cs  = 1'b0;
      cdir = 1'b0;
      car  = 1'b0;
      csg  = 1'b0;
      p    = 0;
      for (int s = 0; s < PIPE_STAGES; s++) begin
         p = (s == 0) ? 0 : s - 1;
         if (s == 0) begin
            vin_n[s] = i_valid;
            cd   = i_data;
            cs   = 1'b0;
            cdir = i_dir;
            car  = i_arith;
            csg  = i_data[SIZE_DATA-1];
            csh  = i_shift_number;
         end else begin
            vin_n[s] = vld_p[p];
            cd   = data_p[p];
            cs   = sticky_p[p];
            cdir = dir_p[p];
            car  = arith_p[p];
            csg  = sign_p[p];
            csh  = shift_p[p];
         end
         for (int k = 0; k < SIZE_SHIFT; k++) begin
            if ((k / BPS) == s && csh[k]) begin
               res = shift_step(cd, cs, cdir, cdir & car & csg, k);
               cd  = res[SIZE_DATA-1:0];
               cs  = res[SIZE_DATA];
            end
         end
         data_n[s]   = cd;
         sticky_n[s] = cs;
         dir_n[s]    = cdir;
         arith_n[s]  = car;
         sign_n[s]   = csg;
         shift_n[s]  = csh;
      end
   end

   // Stage registers: payload only moves when a valid item moves in, so stalled outputs stay put.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         for (int s = 0; s < PIPE_STAGES; s++) begin
            vld_p[s]    <= 1'b0;
            data_p[s]   <= '0;
            sticky_p[s] <= 1'b0;
            dir_p[s]    <= 1'b0;
            arith_p[s]  <= 1'b0;
            sign_p[s]   <= 1'b0;
            shift_p[s]  <= '0;
         end
      end else begin
         for (int s = 0; s < PIPE_STAGES; s++) begin
            if (i_flush)
               vld_p[s] <= 1'b0;
            else if (adv[s])
               vld_p[s] <= vin_n[s];
            if (adv[s] && vin_n[s]) begin
               data_p[s]   <= data_n[s];
               sticky_p[s] <= sticky_n[s];
               dir_p[s]    <= dir_n[s];
               arith_p[s]  <= arith_n[s];
               sign_p[s]   <= sign_n[s];
               shift_p[s]  <= shift_n[s];
            end
         end
      end
   end

   assign o_ready  = adv[0];
   assign o_valid  = vld_p[LAST];
   assign o_data   = data_p[LAST];
   assign o_sticky = sticky_p[LAST];

endmodule

// File: tb/tb_add_sub_shf_pipe.sv
// Bench for add_sub_shf_pipe: directed cases plus random traffic, checked against a queue-based
// arithmetic model of the shifter.
module tb_add_sub_shf_pipe;

   localparam int SD = 32;
   localparam int SS = 5;
   localparam int PS = 2;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          flush;
   logic          i_valid;
   logic          o_ready;
   logic          i_dir;
   logic          i_arith;
   logic [SS-1:0] shn;
   logic [SD-1:0] din;
   logic          o_valid;
   logic          i_ready;
   logic [SD-1:0] o_data;
   logic          o_sticky;

   add_sub_shf_pipe #(.SIZE_DATA(SD), .SIZE_SHIFT(SS), .PIPE_STAGES(PS)) dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_flush(flush), .i_valid(i_valid), .o_ready(o_ready),
      .i_dir(i_dir), .i_arith(i_arith), .i_shift_number(shn), .i_data(din),
      .o_valid(o_valid), .i_ready(i_ready), .o_data(o_data), .o_sticky(o_sticky)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [SD-1:0] d;
      logic          s;
      int            acc;
   } item_t;

   item_t         q[$];
   int            checks = 0;
   int            failures = 0;
   int            cyc = 0;
   logic          chk_lat = 1'b0;
   logic          prev_stall = 1'b0;
   logic [SD-1:0] prev_d;
   logic          prev_s;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Reference: plain shift operators on the whole amount; sticky is every input bit below n.
   function automatic item_t model(input logic dir, input logic ar, input logic [SS-1:0] n,
                                   input logic [SD-1:0] d);
      item_t         it;
      logic [63:0]   m;
      if (!dir)
         it.d = d << n;
      else if (ar)
         it.d = $signed(d) >>> n;
      else
         it.d = d >> n;
      m     = (64'd1 << n) - 64'd1;
      it.s  = dir && (|({32'd0, d} & m));
      it.acc = cyc;
      return it;
   endfunction

   task automatic tick(output logic acc);
      item_t it;
      #3;
      acc = i_valid && o_ready && !flush;
      check("o_ready", o_ready, !(q.size() == PS && !i_ready));
      if (prev_stall) begin
         check("stall_valid", o_valid, 1'b1);
         check("stall_data", o_data, prev_d);
         check("stall_sticky", o_sticky, prev_s);
      end
      if (o_valid && i_ready) begin
         if (q.size() == 0) begin
            check("unexpected_valid", o_valid, 1'b0);
         end else begin
            it = q.pop_front();
            check("o_data", o_data, it.d);
            check("o_sticky", o_sticky, it.s);
            if (chk_lat) check("latency", 32'(cyc - it.acc), 32'(PS));
         end
      end
      prev_stall = o_valid && !i_ready;
      prev_d = o_data;
      prev_s = o_sticky;
      if (flush) begin
         q.delete();
         prev_stall = 1'b0;
      end else if (acc) begin
         q.push_back(model(i_dir, i_arith, shn, din));
      end
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic send(input logic dir, input logic ar, input logic [SS-1:0] n, input logic [SD-1:0] d);
      logic acc;
      acc = 1'b0;
      i_valid = 1'b1;
      i_dir = dir;
      i_arith = ar;
      shn = n;
      din = d;
      for (int t = 0; t < 50; t++) begin
         tick(acc);
         if (acc) break;
      end
      check("send_accepted", acc, 1'b1);
      i_valid = 1'b0;
   endtask

   task automatic drain();
      logic acc;
      i_valid = 1'b0;
      for (int t = 0; t < 60; t++) begin
         if (q.size() == 0) break;
         tick(acc);
      end
      check("drain_empty", q.size(), 0);
   endtask

   task automatic rand_item();
      i_dir   = 1'($urandom);
      i_arith = 1'($urandom);
      shn     = SS'($urandom);
      din     = ($urandom_range(0, 3) == 0) ? 32'h8000_0000 | $urandom : $urandom;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic       acc;
      int         sent;
      logic [3:0] pat;
      rst_n = 1'b1; flush = 1'b0; i_valid = 1'b0; i_dir = 1'b0; i_arith = 1'b0;
      shn = '0; din = '0; i_ready = 1'b1;
      #1 rst_n = 1'b0;
      #2;
      check("reset_valid", o_valid, 1'b0);
      check("reset_data", o_data, 32'h0);
      check("reset_sticky", o_sticky, 1'b0);
      @(posedge clk); @(posedge clk);
      #3 rst_n = 1'b1;
      #1 check("ready_after_reset", o_ready, 1'b1);
      @(posedge clk); #1;

      // T1..T3 directed values with full-rate sink
      chk_lat = 1'b1;
      send(1'b0, 1'b0, 5'd4, 32'h0000_00FF);
      drain();
      send(1'b1, 1'b0, 5'd1, 32'h8000_0001);
      send(1'b1, 1'b0, 5'd31, 32'h8000_0001);
      drain();
      send(1'b1, 1'b1, 5'd31, 32'h8000_0000);
      send(1'b1, 1'b1, 5'd4, 32'h7FFF_FFFF);
      send(1'b1, 1'b1, 5'd0, 32'hDEAD_BEEF);
      send(1'b0, 1'b0, 5'd0, 32'h1234_5678);
      drain();

      // T4 back-to-back stream against a 1,0,0,1 sink pattern
      chk_lat = 1'b0;
      pat = 4'b1001;
      sent = 0;
      rand_item();
      for (int t = 0; t < 200; t++) begin
         if (sent >= 8 && q.size() == 0) break;
         i_ready = pat[t % 4];
         i_valid = (sent < 8);
         tick(acc);
         if (acc) begin
            sent++;
            rand_item();
         end
      end
      check("stream_sent", sent, 8);
      check("stream_drained", q.size(), 0);
      i_ready = 1'b1;
      i_valid = 1'b0;

      // T5 flush two stalled items, then an item right after the flush
      i_ready = 1'b0;
      send(1'b0, 1'b0, 5'd3, 32'h0000_0011);
      send(1'b1, 1'b0, 5'd2, 32'h0000_00F3);
      flush = 1'b1;
      i_valid = 1'b1;
      din = 32'hCAFE_F00D;
      tick(acc);
      flush = 1'b0;
      i_valid = 1'b0;
      check("flush_valid", o_valid, 1'b0);
      check("flush_ready", o_ready, 1'b1);
      i_ready = 1'b1;
      chk_lat = 1'b1;
      send(1'b1, 1'b1, 5'd8, 32'hF000_0F00);
      drain();
      chk_lat = 1'b0;

      // Random traffic with random backpressure and occasional flush
      for (int t = 0; t < 400; t++) begin
         if (!i_valid || acc) rand_item();
         i_valid = ($urandom_range(0, 3) != 0);
         i_ready = ($urandom_range(0, 3) != 0);
         flush   = ($urandom_range(0, 39) == 0);
         tick(acc);
      end
      flush = 1'b0;
      i_ready = 1'b1;
      drain();

      // T6 asynchronous reset in the middle of a stalled stream
      i_ready = 1'b0;
      for (int t = 0; t < 4; t++) begin
         rand_item();
         din = din | 32'h1;
         i_valid = 1'b1;
         tick(acc);
      end
      i_valid = 1'b0;
      #1 rst_n = 1'b0;
      #1;
      check("async_reset_valid", o_valid, 1'b0);
      check("async_reset_data", o_data, 32'h0);
      check("async_reset_sticky", o_sticky, 1'b0);
      q.delete();
      prev_stall = 1'b0;
      i_ready = 1'b1;
      @(posedge clk);
      #3 rst_n = 1'b1;
      #1 check("ready_after_release", o_ready, 1'b1);
      @(posedge clk); #1;
      chk_lat = 1'b1;
      send(1'b0, 1'b0, 5'd31, 32'h0000_0001);
      drain();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
